// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared types and constants for the register-file write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int REG_WIDTH = 16;
   localparam int REG_AW    = 3;
   localparam int NUM_REGS  = 8;
   localparam logic [REG_WIDTH-1:0] RESET_VALUE = 16'h0000;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      ARB  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr.sv
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way round-robin grant; pointer names the requester favoured on a tie.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_valid0,
   input  logic i_valid1,
   output logic o_grant0,
   output logic o_grant1
);

   logic r_rr_ptr;

   always_comb begin
      o_grant0 = 1'b0;
      o_grant1 = 1'b0;
      if (i_en) begin
         if (i_valid0 && i_valid1) begin
            o_grant0 = ~r_rr_ptr;
            o_grant1 = r_rr_ptr;
         end else begin
            o_grant0 = i_valid0;
            o_grant1 = i_valid1;
         end
      end
   end

   // After a grant the other requester becomes the favoured one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= 1'b0;
      end else if (o_grant0) begin
         r_rr_ptr <= 1'b1;
      end else if (o_grant1) begin
         r_rr_ptr <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Owns the register-file write port: init sweep, then round-robin sharing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int               WIDTH      = REG_WIDTH,
   parameter int               AW         = REG_AW,
   parameter bit               INIT_EN    = 1'b1,
   parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(RESET_VALUE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid0,
   input  logic [AW-1:0]    addr0,
   input  logic [WIDTH-1:0] data0,
   output logic             ready0,
   input  logic             valid1,
   input  logic [AW-1:0]    addr1,
   input  logic [WIDTH-1:0] data1,
   output logic             ready1,
   output logic             write,
   output logic [AW-1:0]    writeAdd,
   output logic [WIDTH-1:0] in,
   output logic             init_done,
   output logic             collision
);

   localparam logic [AW:0] c_last_addr   = (AW+1)'((1 << AW) - 1);
   localparam logic [AW:0] c_one         = (AW+1)'(1);
   localparam state_t      c_reset_state = INIT_EN ? INIT : ARB;

   state_t            r_state;
   state_t            w_state_next;
   logic [AW:0]       r_init_cnt;
   logic              r_write;
   logic [AW-1:0]     r_write_add;
   logic [WIDTH-1:0]  r_in;
   logic              r_init_done;
   logic              w_arb_en;
   logic              w_grant0;
   logic              w_grant1;
   logic              w_init_last;

   // Reset suppresses grants so no transfer can be lost in the reset cycle.
   assign w_arb_en    = (r_state == ARB) && !reset;
   assign w_init_last = (r_init_cnt == c_last_addr);

   rr_arbiter2 u_rr_arbiter2 (
      .clk      (clk),
      .rst      (reset),
      .i_en     (w_arb_en),
      .i_valid0 (valid0),
      .i_valid1 (valid1),
      .o_grant0 (w_grant0),
      .o_grant1 (w_grant1)
   );

   assign ready0    = w_grant0;
   assign ready1    = w_grant1;
   assign collision = valid0 && valid1 && (addr0 == addr1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_reset_state;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if ((r_state == INIT) && w_init_last) begin
         w_state_next = ARB;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_write     <= 1'b0;
         r_write_add <= '0;
         r_in        <= '0;
         r_init_done <= !INIT_EN;
         r_init_cnt  <= '0;
      end else if (r_state == INIT) begin
         r_write     <= 1'b1;
         r_write_add <= r_init_cnt[AW-1:0];
         r_in        <= INIT_VALUE;
         r_init_cnt  <= r_init_cnt + c_one;
         if (w_init_last) begin
            r_init_done <= 1'b1;
         end
      end else begin
         // Address and data hold their last values on idle cycles.
         r_write <= w_grant0 | w_grant1;
         if (w_grant0) begin
            r_write_add <= addr0;
            r_in        <= data0;
         end else if (w_grant1) begin
            r_write_add <= addr1;
            r_in        <= data1;
         end
      end
   end

   assign write     = r_write;
   assign writeAdd  = r_write_add;
   assign in        = r_in;
   assign init_done = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module  : tb_regfile_write_arbiter
// Brief   : Scoreboard bench for the register-file write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

   localparam int              AW    = 3;
   localparam int              WIDTH = 16;
   localparam logic [WIDTH-1:0] IV   = 16'h0000;
   localparam int              NEVER = 1 << 30;

   typedef struct {
      int               cyc;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } wr_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             valid0 = 1'b0, valid1 = 1'b0;
   logic [AW-1:0]    addr0 = '0, addr1 = '0;
   logic [WIDTH-1:0] data0 = '0, data1 = '0;
   logic             ready0, ready1, write, init_done, collision;
   logic [AW-1:0]    writeAdd;
   logic [WIDTH-1:0] in;

   logic             n_valid0 = 1'b0, n_valid1 = 1'b0;
   logic [AW-1:0]    n_addr0 = '0, n_addr1 = '0;
   logic [WIDTH-1:0] n_data0 = '0, n_data1 = '0;
   logic             n_ready0, n_ready1, n_write, n_init_done, n_collision;
   logic [AW-1:0]    n_writeAdd;
   logic [WIDTH-1:0] n_in;

   regfile_write_arbiter #(.WIDTH(WIDTH), .AW(AW), .INIT_EN(1'b1), .INIT_VALUE(IV)) dut (
      .clk(clk), .reset(reset),
      .valid0(valid0), .addr0(addr0), .data0(data0), .ready0(ready0),
      .valid1(valid1), .addr1(addr1), .data1(data1), .ready1(ready1),
      .write(write), .writeAdd(writeAdd), .in(in),
      .init_done(init_done), .collision(collision)
   );

   regfile_write_arbiter #(.WIDTH(WIDTH), .AW(AW), .INIT_EN(1'b0), .INIT_VALUE(IV)) dut_ni (
      .clk(clk), .reset(reset),
      .valid0(n_valid0), .addr0(n_addr0), .data0(n_data0), .ready0(n_ready0),
      .valid1(n_valid1), .addr1(n_addr1), .data1(n_data1), .ready1(n_ready1),
      .write(n_write), .writeAdd(n_writeAdd), .in(n_in),
      .init_done(n_init_done), .collision(n_collision)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference state: expected writes with the cycle they must appear in.
   wr_t              exp_q[$];
   logic [WIDTH-1:0] model_rf[8];
   logic [WIDTH-1:0] dut_rf[8];
   int               favour    = 0;
   int               arb_start = NEVER;
   int               done_cyc  = NEVER;
   int               off_cyc   = 0;
   bit               started   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One requester-side cycle: present inputs, compare handshake against the model.
   task automatic drive(input bit v0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1,
                        output bit g0, output bit g1);
      bit  arb, e0, e1;
      wr_t w;
      valid0 = v0; addr0 = a0; data0 = d0;
      valid1 = v1; addr1 = a1; data1 = d1;
      #1;
      arb = !reset && (cyc >= arb_start);
      e0 = 1'b0;
      e1 = 1'b0;
      if (arb) begin
         if (v0 && v1) begin
            e0 = (favour == 0);
            e1 = (favour == 1);
         end else begin
            e0 = v0;
            e1 = v1;
         end
      end
      check("ready0", {31'd0, ready0}, {31'd0, e0});
      check("ready1", {31'd0, ready1}, {31'd0, e1});
      check("collision", {31'd0, collision}, {31'd0, (v0 && v1 && (a0 == a1))});
      if (e0 || e1) begin
         w.cyc  = cyc + 1;
         w.addr = e0 ? a0 : a1;
         w.data = e0 ? d0 : d1;
         exp_q.push_back(w);
         model_rf[w.addr] = w.data;
         favour = e0 ? 1 : 0;
      end
      g0 = e0;
      g1 = e1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      wr_t w;
      valid0 = 1'b0;
      valid1 = 1'b0;
      reset  = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) exp_q.pop_back();
      off_cyc   = (cyc >= done_cyc) ? cyc + 1 : 0;
      done_cyc  = NEVER;
      arb_start = NEVER;
      favour    = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      check("rst_writeAdd", {29'd0, writeAdd}, 32'd0);
      check("rst_in", {16'd0, in}, 32'd0);
      check("rst_write", {31'd0, write}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         w.cyc  = cyc + 1 + k;
         w.addr = 3'(k);
         w.data = IV;
         exp_q.push_back(w);
         model_rf[k] = IV;
      end
      done_cyc  = cyc + 8;
      arb_start = cyc + 8;
      started   = 1'b1;
   endtask

   // Monitor: every cycle the write port must match the head of the queue or be idle.
   always @(negedge clk) begin
      bit  exp_done;
      wr_t w;
      if (started) begin
         exp_done = (cyc >= done_cyc) || (cyc < off_cyc);
         check("init_done", {31'd0, init_done}, {31'd0, exp_done});
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_write: addr %0d data %h never seen (cycle %0d)",
                     exp_q[0].addr, exp_q[0].data, cyc);
            exp_q.pop_front();
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            w = exp_q.pop_front();
            check("write", {31'd0, write}, 32'd1);
            check("writeAdd", {29'd0, writeAdd}, {29'd0, w.addr});
            check("in", {16'd0, in}, {16'd0, w.data});
            if (write === 1'b1) dut_rf[writeAdd] = in;
         end else begin
            check("idle_write", {31'd0, write}, 32'd0);
         end
      end
   end

   initial begin
      bit               g0, g1, p0, p1;
      logic [AW-1:0]    pa0, pa1;
      logic [WIDTH-1:0] pd0, pd1;

      repeat (2) @(posedge clk);
      #1;
      do_reset(1);

      // Instance without init sweep: done at once, accepts on the first cycle.
      check("ni_init_done", {31'd0, n_init_done}, 32'd1);
      check("ni_write_rst", {31'd0, n_write}, 32'd0);
      n_valid1 = 1'b1; n_addr1 = 3'd7; n_data1 = 16'h0042;
      #1;
      check("ni_ready1", {31'd0, n_ready1}, 32'd1);
      check("ni_ready0", {31'd0, n_ready0}, 32'd0);
      drive(0, 0, 0, 0, 0, 0, g0, g1);
      check("ni_write", {31'd0, n_write}, 32'd1);
      check("ni_writeAdd", {29'd0, n_writeAdd}, 32'd7);
      check("ni_in", {16'd0, n_in}, 32'h0042);
      n_valid1 = 1'b0;
      drive(0, 0, 0, 0, 0, 0, g0, g1);
      check("ni_write_idle", {31'd0, n_write}, 32'd0);

      while (cyc < arb_start) drive(0, 0, 0, 0, 0, 0, g0, g1);

      drive(1, 3'd3, 16'hBEEF, 0, 0, 0, g0, g1);
      drive(0, 0, 0, 0, 0, 0, g0, g1);

      // Requesters hold valid through INIT; arbitration then alternates from req0.
      do_reset(1);
      while (cyc < arb_start) drive(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, g0, g1);
      repeat (4) drive(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, g0, g1);

      drive(1, 3'd5, 16'hAAAA, 1, 3'd5, 16'h5555, g0, g1);
      drive(0, 3'd5, 16'hAAAA, 1, 3'd5, 16'h5555, g0, g1);
      drive(0, 0, 0, 0, 0, 0, g0, g1);
      drive(0, 0, 0, 0, 0, 0, g0, g1);
      check("r5_final", {16'd0, dut_rf[5]}, 32'h5555);

      do_reset(1);
      repeat (3) drive(0, 0, 0, 0, 0, 0, g0, g1);
      do_reset(1);

      p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && $urandom_range(0, 99) < 60) begin
            p0 = 1; pa0 = 3'($urandom_range(0, 7)); pd0 = 16'($urandom);
         end else if (p0 && $urandom_range(0, 99) < 10) begin
            p0 = 0;
         end
         if (!p1 && $urandom_range(0, 99) < 60) begin
            p1 = 1; pa1 = 3'($urandom_range(0, 7)); pd1 = 16'($urandom);
         end else if (p1 && $urandom_range(0, 99) < 10) begin
            p1 = 0;
         end
         if (i == 200) do_reset(1);
         drive(p0, pa0, pd0, p1, pa1, pd1, g0, g1);
         if (g0) p0 = 0;
         if (g1) p1 = 0;
      end
      drive(0, 0, 0, 0, 0, 0, g0, g1);
      drive(0, 0, 0, 0, 0, 0, g0, g1);

      for (int k = 0; k < 8; k++) check($sformatf("rf[%0d]", k), {16'd0, dut_rf[k]}, {16'd0, model_rf[k]});
      check("queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
